// File: rtl/mcs4_axi_pkg.sv
// Shared AXI4 types and helpers for the mcs4 AXI burst initiator.
package mcs4_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } master_state_e;

  // Severity order matches the numeric encoding, so the worst response is the max.
  function automatic axi_resp_e resp_max(input axi_resp_e a, input axi_resp_e b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/mcs4_axi_master.sv
// Single-outstanding AXI4 burst initiator: command in, write/read beat streams
// passed through to the W/R channels, one-cycle done pulse with worst response.
module mcs4_axi_master
  import mcs4_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic                    m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic                    m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));

  master_state_e         state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  axi_resp_e             resp_acc;
  logic                  err_q;
  logic                  done_q;
  axi_resp_e             done_resp_q;
  logic                  done_err_q;

  logic                  cmd_ready_c;
  logic                  w_hs;
  logic                  r_hs;
  axi_resp_e             r_resp_fold;
  logic                  r_err_next;
  logic                  unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = len_q;
  assign m_axi_awsize   = AXI_SIZE;
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = '0;
  assign m_axi_awprot   = '0;
  assign m_axi_awqos    = '0;
  assign m_axi_awregion = '0;
  assign m_axi_awuser   = 1'b0;
  assign m_axi_wdata    = wr_data;
  assign m_axi_wstrb    = wr_strb;
  assign m_axi_wuser    = 1'b0;
  assign m_axi_arid     = '0;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = len_q;
  assign m_axi_arsize   = AXI_SIZE;
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = '0;
  assign m_axi_arprot   = '0;
  assign m_axi_arqos    = '0;
  assign m_axi_arregion = '0;
  assign m_axi_aruser   = 1'b0;
  assign rd_data        = m_axi_rdata;
  assign rd_last        = m_axi_rlast;

  // cmd_ready is gated by rst so it stays low for the whole reset interval.
  assign cmd_ready = cmd_ready_c && !rst;
  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign done_err  = done_err_q;

  assign w_hs        = (state == ST_W) && wr_valid && m_axi_wready;
  assign r_hs        = (state == ST_R) && m_axi_rvalid && rd_ready;
  assign r_resp_fold = resp_max(resp_acc, axi_resp_e'(m_axi_rresp));
  // Early rlast, or a beat at/after len without rlast, marks a count mismatch.
  assign r_err_next  = err_q
                     | (m_axi_rlast && (beat_cnt != len_q))
                     | (!m_axi_rlast && (beat_cnt >= len_q));

  always_comb begin
    state_next    = state;
    cmd_ready_c   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) state_next = cmd_write ? ST_AW : ST_AR;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (beat_cnt == len_q);
        if (w_hs && (beat_cnt == len_q)) state_next = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = ST_IDLE;
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = ST_R;
      end
      ST_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (r_hs && m_axi_rlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      resp_acc    <= RESP_OKAY;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= RESP_OKAY;
      done_err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            resp_acc <= RESP_OKAY;
            err_q    <= 1'b0;
          end
        end
        ST_W: begin
          if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            done_q      <= 1'b1;
            done_resp_q <= resp_max(resp_acc, axi_resp_e'(m_axi_bresp));
            done_err_q  <= 1'b0;
          end
        end
        ST_R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_acc <= r_resp_fold;
            err_q    <= r_err_next;
            if (m_axi_rlast) begin
              done_q      <= 1'b1;
              done_resp_q <= r_resp_fold;
              done_err_q  <= r_err_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_axi_master.sv
// Directed bench for mcs4_axi_master with a behavioural AXI slave and a
// transaction-level model checked every cycle on the falling edge.
module tb_mcs4_axi_master;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          done;
  logic [1:0]    done_resp;
  logic          done_err;

  logic [0:0]    awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock, awuser, aruser, wuser;
  logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  mcs4_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awuser(awuser), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wuser(wuser),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_aruser(aruser), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectations, set by the stimulus before each command.
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_len;
  logic [1:0]    exp_resp;
  logic          exp_err;
  logic [31:0]   exp_wdata [8];
  logic [31:0]   exp_rdata [8];

  // Model state advanced on every falling edge.
  bit            exp_busy = 0, exp_done = 0, prev_rst = 0, prev_aw_stall = 0, aw_seen = 0;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;
  int            w_beat = 0, r_beat = 0, aw_cnt = 0, ar_cnt = 0;
  int            wlast_cnt = 0, done_cnt = 0, stall_cycles = 0;

  // Slave model.
  logic [31:0]   mem [256];
  logic [1:0]    cfg_rresp [8];
  logic [1:0]    cfg_bresp;
  int            cfg_rlast_pos;
  int            aw_stall_left = 0, r_idx = 0, r_base = 0, w_ptr = 0;
  bit            r_active = 0, b_pend = 0;
  bit            sl_rst, sl_aw_dec, sl_aw_hs, sl_w_hs, sl_wlast, sl_b_hs, sl_ar_hs, sl_r_hs;
  logic [AW-1:0] sl_waddr, sl_araddr;
  logic [31:0]   sl_wdata;

  assign awready = (aw_stall_left == 0);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign bvalid  = b_pend;
  assign bresp   = cfg_bresp;
  assign bid     = 1'b0;
  assign rid     = 1'b0;
  assign rvalid  = r_active;
  assign rdata   = mem[8'(r_base + r_idx)];
  assign rresp   = cfg_rresp[r_idx & 7];
  assign rlast   = (r_idx == cfg_rlast_pos);

  always @(posedge clk) begin
    #1;
    if (sl_rst) begin
      b_pend   = 0;
      r_active = 0;
    end else begin
      if (sl_aw_dec && aw_stall_left > 0) aw_stall_left--;
      if (sl_aw_hs) w_ptr = int'(sl_waddr) >> 2;
      if (sl_w_hs) begin
        mem[8'(w_ptr)] = sl_wdata;
        w_ptr++;
        if (sl_wlast) b_pend = 1;
      end
      if (sl_b_hs) b_pend = 0;
      if (sl_ar_hs) begin
        r_active = 1;
        r_idx    = 0;
        r_base   = int'(sl_araddr) >> 2;
      end
      if (sl_r_hs) begin
        if (r_idx == cfg_rlast_pos) r_active = 0;
        else r_idx++;
      end
    end
  end

  // Inputs change #1 after the rising edge, so values seen here are what the
  // DUT and slave see at the next rising edge.
  always @(negedge clk) begin
    bit nxt_done;
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (!rst && !exp_busy)});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    if (done) begin
      done_cnt++;
      chk("done_resp", {30'd0, done_resp}, {30'd0, exp_resp});
      chk("done_err", {31'd0, done_err}, {31'd0, exp_err});
    end
    if (prev_rst)
      chk("valids_after_reset", {25'd0, awvalid, arvalid, wvalid, rd_valid, wr_ready, rready, bready}, 32'd0);
    if (prev_aw_stall)
      chk("aw_hold", {9'd0, awvalid, awaddr, awlen}, {9'd0, 1'b1, prev_awaddr, prev_awlen});
    if (!exp_busy)
      chk("idle_valids", {28'd0, awvalid, arvalid, wvalid, rd_valid}, 32'd0);
    if (!aw_seen)
      chk("w_before_aw", {31'd0, wvalid}, 32'd0);

    {sl_aw_dec, sl_aw_hs, sl_w_hs, sl_wlast, sl_b_hs, sl_ar_hs, sl_r_hs} = '0;
    sl_rst        = rst;
    prev_aw_stall = 0;
    nxt_done      = 0;
    if (rst) begin
      exp_busy = 0;
      aw_seen  = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_busy = 1;
        aw_seen  = 0;
        w_beat   = 0;
        r_beat   = 0;
      end
      if (awvalid) begin
        if (awready) begin
          chk("aw_fields", {4'd0, awaddr, awlen, awsize, awburst, awid},
              {4'd0, exp_addr, exp_len, 3'd2, 2'b01, 1'b0});
          chk("aw_side", {13'd0, awlock, awcache, awprot, awqos, awregion, awuser}, 32'd0);
          aw_cnt++;
          aw_seen  = 1;
          sl_aw_hs = 1;
          sl_waddr = awaddr;
        end else begin
          prev_aw_stall = 1;
          stall_cycles++;
          sl_aw_dec = 1;
        end
      end
      if (arvalid && arready) begin
        chk("ar_fields", {4'd0, araddr, arlen, arsize, arburst, arid},
            {4'd0, exp_addr, exp_len, 3'd2, 2'b01, 1'b0});
        chk("ar_side", {13'd0, arlock, arcache, arprot, arqos, arregion, aruser}, 32'd0);
        ar_cnt++;
        sl_ar_hs  = 1;
        sl_araddr = araddr;
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, exp_wdata[w_beat & 7]);
        chk("wstrb_wuser", {27'd0, wstrb, wuser}, {27'd0, 4'hF, 1'b0});
        chk("wlast", {31'd0, wlast}, {31'd0, (w_beat == int'(exp_len))});
        if (wlast) wlast_cnt++;
        sl_w_hs  = 1;
        sl_wlast = wlast;
        sl_wdata = wdata;
        w_beat++;
      end
      if (bvalid && bready) begin
        nxt_done = 1;
        exp_busy = 0;
        sl_b_hs  = 1;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, exp_rdata[r_beat & 7]);
        chk("rd_last", {31'd0, rd_last}, {31'd0, (r_beat == cfg_rlast_pos)});
        if (rd_last) begin
          nxt_done = 1;
          exp_busy = 0;
        end
        sl_r_hs = 1;
        r_beat++;
      end
    end
    exp_done    = nxt_done;
    prev_rst    = rst;
    prev_awaddr = awaddr;
    prev_awlen  = awlen;
  end

  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    bit ok;
    ok        = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 0;
    chk("cmd_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic write_beats(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      ok       = 0;
      wr_data  = exp_wdata[i];
      wr_strb  = 4'hF;
      wr_valid = 1;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (wr_ready) begin
          ok = 1;
          break;
        end
      end
      @(posedge clk);
      #1;
      chk("wr_ready_timeout", {31'd0, ok}, 32'd1);
    end
    wr_valid = 0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic read_run(input bit toggle);
    bit seen;
    seen     = 0;
    rd_ready = 1;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk);
      #1;
      rd_ready = toggle ? !rd_ready : 1'b1;
    end
    rd_ready = 0;
    chk("read_done_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int done_before;
    rst       = 1;
    cmd_valid = 0;
    cmd_write = 0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_strb   = '0;
    wr_valid  = 0;
    rd_ready  = 0;
    cfg_bresp = 2'b00;
    cfg_rlast_pos = 3;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 8; i++) begin
      cfg_rresp[i] = 2'b00;
      exp_wdata[i] = '0;
      exp_rdata[i] = '0;
    end
    exp_addr = '0;
    exp_len  = '0;
    exp_resp = 2'b00;
    exp_err  = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_done_resp_err", {29'd0, done_resp, done_err}, 32'd0);
    @(posedge clk);
    #1;

    // 4-beat write, slave always ready
    exp_addr = 14'h0000;
    exp_len  = 8'd3;
    exp_wdata[0] = 32'h11; exp_wdata[1] = 32'h22; exp_wdata[2] = 32'h33; exp_wdata[3] = 32'h44;
    do_cmd(1'b1, 14'h0000, 8'd3);
    write_beats(4);
    wait_done();
    chk("t1_aw_count", aw_cnt, 32'd1);
    chk("t1_wlast_count", wlast_cnt, 32'd1);
    chk("t1_mem3", mem[3], 32'h44);
    chk("t1_done_count", done_cnt, 32'd1);

    // 4-beat read with rd_ready toggling
    exp_rdata[0] = 32'h11; exp_rdata[1] = 32'h22; exp_rdata[2] = 32'h33; exp_rdata[3] = 32'h44;
    cfg_rlast_pos = 3;
    do_cmd(1'b0, 14'h0000, 8'd3);
    read_run(1'b1);
    chk("t2_beats", r_beat, 32'd4);
    chk("t2_ar_count", ar_cnt, 32'd1);

    // AW stalled 5 cycles, DECERR write response
    exp_addr = 14'h0040;
    exp_len  = 8'd1;
    exp_wdata[0] = 32'h55; exp_wdata[1] = 32'h66;
    cfg_bresp = 2'b11;
    exp_resp  = 2'b11;
    stall_cycles  = 0;
    aw_stall_left = 5;
    do_cmd(1'b1, 14'h0040, 8'd1);
    write_beats(2);
    wait_done();
    chk("t3_stall_cycles", stall_cycles, 32'd5);
    chk("t3_mem17", mem[17], 32'h66);
    cfg_bresp = 2'b00;

    // SLVERR on beat 2 of a 4-beat read
    exp_addr = 14'h0000;
    exp_len  = 8'd3;
    cfg_rresp[1] = 2'b10;
    exp_resp = 2'b10;
    exp_err  = 0;
    do_cmd(1'b0, 14'h0000, 8'd3);
    read_run(1'b0);
    chk("t4_beats", r_beat, 32'd4);
    cfg_rresp[1] = 2'b00;

    // rlast early on beat 2 of len=3
    cfg_rlast_pos = 1;
    exp_resp = 2'b00;
    exp_err  = 1;
    do_cmd(1'b0, 14'h0000, 8'd3);
    read_run(1'b0);
    chk("t5_beats", r_beat, 32'd2);

    // rlast late: one extra beat drained beyond len
    cfg_rlast_pos = 4;
    exp_rdata[4]  = 32'hA000_0004;
    exp_err       = 1;
    do_cmd(1'b0, 14'h0000, 8'd3);
    read_run(1'b0);
    chk("t6_beats", r_beat, 32'd5);
    cfg_rlast_pos = 3;
    exp_err = 0;

    // Back-to-back single-beat writes; second command waits on cmd_ready
    done_before  = done_cnt;
    exp_addr     = 14'h0080;
    exp_len      = 8'd0;
    exp_wdata[0] = 32'h77;
    do_cmd(1'b1, 14'h0080, 8'd0);
    write_beats(1);
    exp_addr     = 14'h0084;
    exp_wdata[0] = 32'h88;
    do_cmd(1'b1, 14'h0084, 8'd0);
    write_beats(1);
    wait_done();
    chk("t7_done_count", done_cnt - done_before, 32'd2);
    chk("t7_mem33", mem[33], 32'h88);

    // Reset during first beat of a 4-beat write
    done_before  = done_cnt;
    exp_addr     = 14'h0100;
    exp_len      = 8'd3;
    exp_wdata[0] = 32'hA1; exp_wdata[1] = 32'hA2; exp_wdata[2] = 32'hA3; exp_wdata[3] = 32'hA4;
    do_cmd(1'b1, 14'h0100, 8'd3);
    write_beats(1);
    rst      = 1;
    wr_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t8_no_done", done_cnt, done_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcs4_axi_master.md
# mcs4_axi_master

AXI4 burst initiator that drives the `mcs4_sys` AXI4 slave port (ROM image load, RAM/IO readback) from a simple command, write-stream and read-stream interface. It sits between a host-side sequencer (bench or PS-side controller) and `mcs4_sys`, and owns the AW/W/B and AR/R handshakes. It runs one transaction at a time, with no outstanding-transaction overlap.

## Interface
- `ADDR_WIDTH`, 14: AXI address width; must match the slave.
- `DATA_WIDTH`, 32: AXI data width; the byte count per beat is `DATA_WIDTH/8`.
- `ID_WIDTH`, 1: AXI ID width; all IDs are driven as 0.
- `clk`  in  1: the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_valid` / `cmd_ready`  in/out  1: command handshake.
- `cmd_write`  in  1: 1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_WIDTH: start byte address; must be beat-aligned.
- `cmd_len`  in  8: beats minus 1, placed directly on `awlen`/`arlen`.
- `wr_data` / `wr_strb`  in  DATA_WIDTH / DATA_WIDTH/8: write beat payload.
- `wr_valid` / `wr_ready`  in/out  1: write-stream handshake.
- `rd_data`  out  DATA_WIDTH: read beat payload.
- `rd_last`  out  1: marks the final read beat.
- `rd_valid` / `rd_ready`  out/in  1: read-stream handshake.
- `done`  out  1: one-cycle pulse when a transaction completes.
- `done_resp`  out  2: worst AXI response seen during the transaction, valid while `done` is high.
- `done_err`  out  1: beat-count/last mismatch, valid while `done` is high.
- `m_axi_awid/awaddr/awlen/awvalid/awready`, `m_axi_wdata/wstrb/wlast/wvalid/wready`, `m_axi_bid/bresp/bvalid/bready`, `m_axi_arid/araddr/arlen/arvalid/arready`, `m_axi_rid/rdata/rresp/rlast/rvalid/rready`: standard AXI4 master channels.
- `m_axi_awsize/arsize` = log2(DATA_WIDTH/8), `m_axi_awburst/arburst` = INCR (2'b01). `lock/cache/prot/qos/region/user` outputs are driven as 0.

## Operation
- **State machine** `IDLE → AW → W → B → IDLE` for writes and `IDLE → AR → R → IDLE` for reads.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, latch addr, len and write.
  - Clear the beat counter, the response accumulator and the error flag.
  - Go to AW or AR.
- **AW / AR**
  - Hold `awvalid` (or `arvalid`) high with the latched addr/len until `awready` (or `arready`).
  - Then go to W (or R).
  - Address is presented before any W beat; no write-data-before-address.
- **W**
  - Combinational pass-through: `m_axi_wvalid = wr_valid` and `wr_ready = m_axi_wready`. Data and strobe are passed straight through.
  - `wlast` = (beat count == latched len).
  - Counter increments on each `wvalid && wready`.
  - When the last beat is accepted, go to B.
- **B**
  - `bready` = 1.
  - On `bvalid`, fold `bresp` into the accumulator, pulse `done`, return to IDLE.
- **R**
  - Pass-through: `rd_valid = m_axi_rvalid`, `m_axi_rready = rd_ready`, `rd_data = rdata`, `rd_last = rlast`.
  - Each accepted beat folds `rresp` (max severity: OKAY < EXOKAY < SLVERR < DECERR, compared numerically) and increments the counter.
  - Completion is on the accepted beat with `rlast`.
  - If `rlast` arrives early, or the count reaches len without `rlast`, set `done_err` and end at the `rlast` beat.
  - Beats beyond len are still accepted and drained.
- Outside W and R, `wr_ready`, `rd_valid`, `m_axi_wvalid` and `m_axi_rready` are all 0.
- A burst crossing 4 KB, or an unaligned `cmd_addr`, is the caller's error; the block does not check for it.

## Timing
- **Reset values**
  - `cmd_ready` = 0 during reset and 1 in the first IDLE cycle after reset.
  - All `m_axi_*valid`, `bready`, `rready`, `done` = 0.
  - `done_resp` = 0, `done_err` = 0, state = IDLE.
- **Command latency**
  - Command accepted at edge N: `awvalid`/`arvalid` high from cycle N+1, registered.
  - `cmd_ready` drops at N+1.
- **Address phase:** AW/AR handshake at edge M puts the block in W/R at M+1; the earliest first data beat is M+1.
- **Write completion:** `done` is high for the cycle after the `bvalid && bready` edge. `cmd_ready` returns in that same cycle, so back-to-back commands lose exactly one cycle.
- **Read completion:** `done` is high for the cycle after the `rlast` beat handshake.
- **Handshake rules:** once asserted, a valid never deasserts or changes payload before its ready. `awaddr`/`awlen` are stable throughout AW.
- **Reset mid-burst:** all valids and readies drop at the reset edge, with no completion of the burst and no `done`. The slave must be reset together with this block.
- **Single-beat write (len=0):** `wlast` is high on the first beat.
- **Single-beat read (len=0):** `rlast` is expected on the first beat.

## Structure
- Shared package `mcs4_axi_pkg` holds:
  - `axi_resp_e` (OKAY/EXOKAY/SLVERR/DECERR)
  - `axi_burst_e` (FIXED/INCR/WRAP)
  - `master_state_e`
  - the response-max function
- No sub-module: one FSM, one 8-bit beat counter, latched command registers.

## Test plan
- **Write burst:** write addr 0x0000, len 3, data 0x11,0x22,0x33,0x44 with slave `wready` always 1 → AW seen once with len 3; `wlast` only on 0x44; `done` with `done_resp`=0 one cycle after B.
- **Read burst with backpressure:** read addr 0x0000, len 3, `rd_ready` toggled every other cycle → 4 beats delivered in order with `rd_last` on beat 4; no beat is lost or duplicated.
- **Stalled address:** slave holds `awready` low for 5 cycles → `awvalid` and `awaddr` stay stable for all 5 cycles; no W beat before the handshake.
- **Error response:** slave returns SLVERR on beat 2 of a 4-beat read, OKAY elsewhere → `done_resp`=2'b10, `done_err`=0.
- **Early last:** slave asserts `rlast` on beat 2 of a len=3 read → completion at beat 2 with `done_err`=1.
- **Reset mid-burst:** reset during beat 1 of a 4-beat write → all valids are 0 on the next cycle, no `done` pulse, and `cmd_ready`=1 in the first cycle after reset deasserts.
